// File: rtl/cache_repl_pkg.sv
// Shared replacement-policy definitions for the cache victim selector:
// LFSR tap masks, policy mode encoding and index-width helper.
package cache_repl_pkg;

    localparam logic MODE_LFSR = 1'b0;
    localparam logic MODE_RR   = 1'b1;

    // Fibonacci maximal-length taps, bit i set = state bit i feeds the XOR
    function automatic logic [15:0] lfsr_taps(input int width);
        logic [15:0] m;
        case (width)
            3:       m = 16'h0006;
            4:       m = 16'h000C;
            5:       m = 16'h0014;
            6:       m = 16'h0030;
            7:       m = 16'h0060;
            8:       m = 16'h00B8;
            9:       m = 16'h0110;
            10:      m = 16'h0240;
            11:      m = 16'h0500;
            12:      m = 16'h0829;
            13:      m = 16'h100D;
            14:      m = 16'h2015;
            15:      m = 16'h6000;
            16:      m = 16'hD008;
            default: m = 16'h0000;
        endcase
        return m;
    endfunction

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cache_victim_sel_rotate_prio_enc.sv
// Rotating priority encoder: first request at or after base, with wrap.
module rotate_prio_enc
    import cache_repl_pkg::*;
#(
    parameter  int N  = 4,
    localparam int IW = idx_w(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] base_i,
    output logic [N-1:0]  gnt_o,
    output logic          any_o
);

    logic [N-1:0] rot;
    logic [N-1:0] low;

    // rotate so base sits at bit 0, isolate lowest bit, rotate back
    always_comb begin
        rot   = N'({req_i, req_i} >> base_i);
        low   = rot & (~rot + N'(1));
        gnt_o = N'({low, low} << base_i >> N);
        any_o = |req_i;
    end

endmodule

// File: rtl/cache_victim_sel.sv
// Victim-way selector: invalid-way priority, then LFSR or round-robin
// search over unlocked ways; state advances only on committed fills.
module cache_victim_sel
    import cache_repl_pkg::*;
#(
    parameter int               NUMWAYS = 4,
    parameter int               LFSRW   = 8,
    parameter logic [LFSRW-1:0] SEED    = 'h01
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               FlushStage,
    input  logic               CacheEn,
    input  logic               LRUWriteEn,
    input  logic               SetValid,
    input  logic               InvalidateCache,
    input  logic [NUMWAYS-1:0] ValidWay,
    input  logic [NUMWAYS-1:0] WayLock,
    input  logic               Mode,
    output logic [NUMWAYS-1:0] VictimWay,
    output logic               VictimOk,
    output logic [LFSRW-1:0]   LFSRState
);

    localparam int               IW       = idx_w(NUMWAYS);
    localparam logic [15:0]      TAPS_ALL = lfsr_taps(LFSRW);
    localparam logic [LFSRW-1:0] TAPS     = TAPS_ALL[LFSRW-1:0];

    logic [LFSRW-1:0]   lfsr_q, lfsr_d;
    logic [IW-1:0]      rr_q, rr_d;
    logic [NUMWAYS-1:0] cand, inval, inval_oh, rot_oh;
    logic [IW-1:0]      base, victim_idx;
    logic               rot_any, advance;

    rotate_prio_enc #(.N(NUMWAYS)) u_rot (
        .req_i  (cand),
        .base_i (base),
        .gnt_o  (rot_oh),
        .any_o  (rot_any)
    );

    always_comb begin
        cand      = ~WayLock;
        inval     = cand & ~ValidWay;
        inval_oh  = inval & (~inval + NUMWAYS'(1));
        base      = (Mode == MODE_RR) ? rr_q : lfsr_q[IW-1:0];
        VictimWay = (|inval) ? inval_oh : rot_oh;
        VictimOk  = rot_any;
        LFSRState = lfsr_q;
        advance   = CacheEn & LRUWriteEn & SetValid & ~FlushStage;
    end

    always_comb begin
        victim_idx = '0;
        for (int i = 0; i < NUMWAYS; i++) begin
            if (VictimWay[i]) victim_idx = victim_idx | IW'(i);
        end
    end

    always_comb begin
        lfsr_d = lfsr_q;
        if (lfsr_q == '0)
            lfsr_d = SEED;
        else if (advance)
            lfsr_d = {lfsr_q[LFSRW-2:0], ^(lfsr_q & TAPS)};
    end

    // pointer follows the chosen victim, whichever priority picked it
    always_comb begin
        rr_d = rr_q;
        if (InvalidateCache)
            rr_d = '0;
        else if (advance && VictimOk)
            rr_d = victim_idx + IW'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lfsr_q <= SEED;
            rr_q   <= '0;
        end else begin
            lfsr_q <= lfsr_d;
            rr_q   <= rr_d;
        end
    end

endmodule

// File: doc/cache_victim_sel.md
Name: cache_victim_sel

Overview:
Parametrised victim-way selector for the set-associative cache. It replaces the fixed LFSR replacement block and adds a runtime-selectable policy (pseudo-random LFSR or round-robin), invalid-way priority and per-way lockout. It sits beside the tag/valid arrays and feeds VictimWay to the fill/writeback datapath.

Parameters:
NUMWAYS, 4, number of ways; power of two, at least 2
LFSRW, 8, LFSR width; range 3..16, at least log2(NUMWAYS)+1
SEED, 8'h01, LFSR reset value; must be nonzero

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-low reset (asserted at 0)
FlushStage  input  1  squash; blocks state advance
CacheEn  input  1  cache arrays enabled
LRUWriteEn  input  1  replacement-state update request
SetValid  input  1  line fill commits the victim this cycle
InvalidateCache  input  1  all valid bits being cleared
ValidWay  input  NUMWAYS  valid bits of the indexed set
WayLock  input  NUMWAYS  1 = way excluded from replacement
Mode  input  1  0 = LFSR, 1 = round-robin
VictimWay  output  NUMWAYS  one-hot victim, or all-zero
VictimOk  output  1  a legal victim exists
LFSRState  output  LFSRW  debug view of the LFSR

Behaviour:
- Reset (reset=0, async): LFSR <= SEED; RR pointer <= 0. Outputs are combinational from state, so VictimWay and VictimOk follow from ValidWay/WayLock immediately.
- Advance = CacheEn & LRUWriteEn & SetValid & ~FlushStage. No state changes otherwise.
- LFSR: Fibonacci, shifts left; new LSB = XOR of tap bits taken from the package table (LFSRW=8: bits 7,5,4,3). Steps once per Advance, in either Mode, so the random sequence is independent of Mode. If the state is ever 0, it loads SEED on the next clock.
- Candidates: Cand = ~WayLock.
- Priority 1: if any (Cand & ~ValidWay) is set, the victim is the lowest-index such way. This holds in both modes.
- Priority 2 (all candidates valid): base index B = LFSR[log2(NUMWAYS)-1:0] when Mode=0, or RR pointer when Mode=1. The victim is the first candidate at B, B+1, ..., searching with wrap modulo NUMWAYS.
- VictimWay is one-hot. If Cand==0, VictimWay=0 and VictimOk=0; otherwise VictimOk=1.
- RR pointer: on Advance, it loads (index of the current victim + 1) mod NUMWAYS, including when the victim came from invalid priority. It is held if VictimOk=0.
- InvalidateCache: clears the RR pointer to 0 the next clock, with priority over Advance. The LFSR is unaffected.
- Mode change: takes effect in the same cycle, combinationally. No state is lost.
- Zero-latency output; the state update lands on the clock edge after Advance.

Decomposition:
- Package cache_repl_pkg: LFSR tap-mask function lfsr_taps(width) for 3..16, the Mode encoding constants, and a clog2-based index-width helper.
- Sub-module rotate_prio_enc(N): takes a request vector and a base index, and returns a one-hot first-set-at-or-after-base with wrap, plus an any flag. It is used for the priority-2 search. Priority 1 is a plain low-index priority encoder.

Test Plan:
All scenarios use NUMWAYS=4, LFSRW=8, SEED=01.
1. Reset, Mode=0, ValidWay=1111, WayLock=0000 -> LFSRState=01, VictimWay=0010. After one Advance -> LFSRState=02, VictimWay=0100. After Advances 3 and 4 -> states 08, then 11.
2. ValidWay=1011, WayLock=0000, either Mode -> VictimWay=0100 regardless of LFSR or RR. ValidWay=0011 -> VictimWay=0100 (lowest invalid way).
3. Mode=1, ValidWay=1111, four Advances -> VictimWay sequence 0001, 0010, 0100, 1000, then wraps to 0001. Then InvalidateCache concurrent with Advance -> pointer=0 and VictimWay=0001.
4. Mode=1, pointer=2, WayLock=0100 -> VictimWay=1000. WayLock=1100 -> VictimWay=0001 (wrap). WayLock=1111 -> VictimWay=0000, VictimOk=0, and Advance leaves the pointer unchanged.
5. Advance with FlushStage=1, or CacheEn=0, or SetValid=0 -> LFSRState and pointer unchanged. Assert reset mid-sequence (LFSR=11) asynchronously -> LFSRState=01 before the next edge.
6. Random ValidWay/WayLock/Mode over 10k cycles against a reference model -> VictimWay is always one-hot or zero, never selects a locked way, and VictimOk equals |~WayLock.
